// File: rtl/key_debounce_multi.sv
// key_debounce_multi: N_KEYS active-low key debouncers with level,
// press/release pulses, press toggle and optional long-press pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   key          raw key pins, 0 = pressed, asynchronous to clk
//   key_level    debounced level, 1 = pressed
//   key_press    1-cycle pulse on accepted press
//   key_release  1-cycle pulse on accepted release
//   key_toggle   flips on every key_press
//   key_long     1-cycle long-press pulse
//
// Build option: define KEY_LONGPRESS_EN to add the per-channel hold
// counter; without it key_long is constant 0.
module key_debounce_multi #(
   parameter int N_KEYS   = 4,
   parameter int DEB_CNT  = 1_000_000,
   parameter int CNT_W    = 20,
   parameter int LONG_CNT = 50_000_000,
   parameter int LONG_W   = 26
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_toggle,
   output logic [N_KEYS-1:0] key_long
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_DEB,
      PRESSED,
      REL_DEB
   } state_t;

   // The entry cycle already saw the new level, so the count
   // completes one short of DEB_CNT.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

`ifdef KEY_LONGPRESS_EN
   localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);
   localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CNT);
`endif

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      logic             sync1;
      logic             s;
      state_t           state;
      state_t           state_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             press_ev;
      logic             rel_ev;
      logic             level_q;
      logic             press_q;
      logic             rel_q;
      logic             tog_q;

      // Two-flop synchroniser, idles at "released".
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
         end else begin
            sync1 <= key[i];
            s     <= sync1;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
         end
      end

      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         press_ev  = 1'b0;
         rel_ev    = 1'b0;
         unique case (state)
            IDLE: begin
               if (!s) begin
                  state_nxt = PRESS_DEB;
                  cnt_nxt   = '0;
               end
            end
            PRESS_DEB: begin
               if (s) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nxt = PRESSED;
                  cnt_nxt   = '0;
                  press_ev  = 1'b1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (s) begin
                  state_nxt = REL_DEB;
                  cnt_nxt   = '0;
               end
            end
            REL_DEB: begin
               if (!s) begin
                  state_nxt = PRESSED;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
                  rel_ev    = 1'b1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            tog_q   <= 1'b0;
         end else begin
            press_q <= press_ev;
            rel_q   <= rel_ev;
            if (press_ev) begin
               level_q <= 1'b1;
               tog_q   <= ~tog_q;
            end else if (rel_ev) begin
               level_q <= 1'b0;
            end
         end
      end

      assign key_level[i]   = level_q;
      assign key_press[i]   = press_q;
      assign key_release[i] = rel_q;
      assign key_toggle[i]  = tog_q;

`ifdef KEY_LONGPRESS_EN
      logic [LONG_W-1:0] hold;
      logic              holding;
      logic              long_ev;
      logic              long_q;

      // Counting only while the key is accepted as down means an
      // accepted release stops it until the next press clears it.
      assign holding = (state == PRESSED) || (state == REL_DEB);
      assign long_ev = holding && !rel_ev && (hold == LONG_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            hold   <= '0;
            long_q <= 1'b0;
         end else begin
            long_q <= long_ev;
            if (press_ev) begin
               hold <= '0;
            end else if (holding && (hold != LONG_MAX)) begin
               hold <= hold + 1'b1;
            end
         end
      end

      assign key_long[i] = long_q;
`else
      assign key_long[i] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed scenarios plus random
// bouncing, all compared every cycle against a run-length model.
module tb_key_debounce_multi;

   localparam int N    = 4;
   localparam int DEB  = 8;
   localparam int CW   = 4;
   localparam int LONG = 32;
   localparam int LW   = 6;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] key = '1;
   logic [N-1:0] key_level;
   logic [N-1:0] key_press;
   logic [N-1:0] key_release;
   logic [N-1:0] key_toggle;
   logic [N-1:0] key_long;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   key_debounce_multi #(
      .N_KEYS  (N),
      .DEB_CNT (DEB),
      .CNT_W   (CW),
      .LONG_CNT(LONG),
      .LONG_W  (LW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key        (key),
      .key_level  (key_level),
      .key_press  (key_press),
      .key_release(key_release),
      .key_toggle (key_toggle),
      .key_long   (key_long)
   );

   // Reference: raw pin delayed two samples; level flips once the
   // delayed pin disagrees with it for DEB+1 consecutive samples.
   logic [N-1:0] m_h1, m_h2, m_level, m_press, m_rel;
   logic [N-1:0] m_tog, m_long, m_fired;
   int           m_run [N];
   int           m_held[N];

   task automatic model_reset();
      m_h1    = '1;
      m_h2    = '1;
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      m_tog   = '0;
      m_long  = '0;
      m_fired = '0;
      for (int c = 0; c < N; c++) begin
         m_run[c]  = 0;
         m_held[c] = 0;
      end
   endtask

   task automatic model_step();
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int c = 0; c < N; c++) begin
         logic sp;
         logic was;
         sp = ~m_h2[c];
         m_h2[c] = m_h1[c];
         m_h1[c] = key[c];
         m_press[c] = 1'b0;
         m_rel[c]   = 1'b0;
         m_long[c]  = 1'b0;
         was = m_level[c];
         if (sp != m_level[c]) m_run[c]++;
         else m_run[c] = 0;
         if (m_run[c] == DEB + 1) begin
            m_run[c] = 0;
            m_level[c] = sp;
            if (sp) begin
               m_press[c] = 1'b1;
               m_tog[c]   = ~m_tog[c];
               m_held[c]  = 0;
               m_fired[c] = 1'b0;
            end else begin
               m_rel[c] = 1'b1;
            end
         end
         if (was && m_level[c]) begin
            m_held[c]++;
`ifdef KEY_LONGPRESS_EN
            if (m_held[c] == LONG && !m_fired[c]) begin
               m_long[c]  = 1'b1;
               m_fired[c] = 1'b1;
            end
`endif
         end
      end
   endtask

   function automatic logic [5*N-1:0] dut_vec();
      return {key_level, key_press, key_release,
              key_toggle, key_long};
   endfunction

   function automatic logic [5*N-1:0] exp_vec();
      return {m_level, m_press, m_rel, m_tog, m_long};
   endfunction

   // One clock: model updates on the edge, outputs sampled 1 ns later.
   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      key   = '1;
      model_reset();
      #2;
      checks++;
      if (dut_vec() !== '0) begin
         errors++;
         $display("FAIL reset: got %h want 0", dut_vec());
      end
      for (int e = 0; e < 3; e++) cyc();
      rst_n = 1'b1;
      for (int e = 0; e < 4; e++) begin
         cyc();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h",
                     dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_single_press();
      key[0] = 1'b0;
      for (int e = 0; e < 16; e++) begin
         cyc();
         checks++;
         if (key_press[0] !== (e == 10)) begin
            errors++;
            $display("FAIL press0 e=%0d: got %b want %b",
                     e, key_press[0], e == 10);
         end
         checks++;
         if ({key_level[0], key_toggle[0]} !== {2{e >= 10}}) begin
            errors++;
            $display("FAIL level0 e=%0d: got %b%b want %b",
                     e, key_level[0], key_toggle[0], e >= 10);
         end
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL press_model e=%0d: got %h want %h",
                     e, dut_vec(), exp_vec());
         end
      end
      key[0] = 1'b1;
      for (int e = 0; e < 14; e++) begin
         cyc();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL rel_model e=%0d: got %h want %h",
                     e, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_bounce();
      for (int e = 0; e < 30; e++) begin
         key[1] = !((e < 5) || (e >= 7 && e < 12));
         cyc();
         checks++;
         if ({key_press, key_release, key_level[1]} !== '0) begin
            errors++;
            $display("FAIL bounce e=%0d: got %b %b %b want 0",
                     e, key_press, key_release, key_level[1]);
         end
      end
   endtask

   task automatic test_toggle();
      int npress;
      for (int rep = 0; rep < 2; rep++) begin
         npress = 0;
         for (int e = 0; e < 46; e++) begin
            if (e == 0) key[2] = 1'b0;
            if (e == 22) key[2] = 1'b1;
            cyc();
            if (key_press[2]) npress++;
            checks++;
            if (key_release[2] !== (e == 32)) begin
               errors++;
               $display("FAIL rel2 e=%0d: got %b want %b",
                        e, key_release[2], e == 32);
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL toggle_model e=%0d: got %h want %h",
                        e, dut_vec(), exp_vec());
            end
         end
         checks++;
         if (npress != 1) begin
            errors++;
            $display("FAIL npress2: got %0d want 1", npress);
         end
         checks++;
         if (key_toggle[2] !== (rep == 0)) begin
            errors++;
            $display("FAIL toggle2 rep=%0d: got %b want %b",
                     rep, key_toggle[2], rep == 0);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [N-1:0] want;
      key[0] = 1'b0;
      key[3] = 1'b0;
      for (int e = 0; e < 15; e++) begin
         cyc();
         want = (e == 10) ? 4'b1001 : 4'b0000;
         checks++;
         if (key_press !== want) begin
            errors++;
            $display("FAIL simul e=%0d: got %b want %b",
                     e, key_press, want);
         end
      end
      key = '1;
      for (int e = 0; e < 15; e++) begin
         cyc();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL simul_rel e=%0d: got %h want %h",
                     e, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      key[0] = 1'b0;
      for (int e = 0; e < 8; e++) cyc();
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_vec() !== '0) begin
         errors++;
         $display("FAIL reset_mid: got %h want 0", dut_vec());
      end
      for (int e = 0; e < 3; e++) cyc();
      rst_n = 1'b1;
      for (int e = 0; e < 15; e++) begin
         cyc();
         checks++;
         if (key_press[0] !== (e == 10)) begin
            errors++;
            $display("FAIL reset_press e=%0d: got %b want %b",
                     e, key_press[0], e == 10);
         end
      end
      checks++;
      if (key_toggle !== 4'b0001) begin
         errors++;
         $display("FAIL reset_toggle: got %b want 0001", key_toggle);
      end
      key[0] = 1'b1;
      for (int e = 0; e < 14; e++) cyc();
   endtask

   task automatic test_long();
      int nlong;
      int at;
      for (int rep = 0; rep < 2; rep++) begin
         nlong = 0;
         at = -1;
         for (int e = 0; e < 76; e++) begin
            if (e == 0) key[0] = 1'b0;
            if (e == (rep == 0 ? 60 : 30)) key[0] = 1'b1;
            cyc();
            if (key_long[0]) begin
               nlong++;
               at = e;
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL long_model e=%0d: got %h want %h",
                        e, dut_vec(), exp_vec());
            end
         end
`ifdef KEY_LONGPRESS_EN
         checks++;
         if (nlong != (rep == 0 ? 1 : 0)) begin
            errors++;
            $display("FAIL nlong rep=%0d: got %0d want %0d",
                     rep, nlong, rep == 0 ? 1 : 0);
         end
         if (rep == 0) begin
            checks++;
            if (at != 42) begin
               errors++;
               $display("FAIL long_at: got %0d want 42", at);
            end
         end
`else
         checks++;
         if (nlong != 0) begin
            errors++;
            $display("FAIL long_off: got %0d pulses at %0d want 0",
                     nlong, at);
         end
`endif
      end
   endtask

   task automatic test_random();
      for (int e = 0; e < 2000; e++) begin
         for (int c = 0; c < N; c++)
            if ($urandom_range(0, 9) == 0) key[c] = ~key[c];
         cyc();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random e=%0d: got %h want %h",
                     e, dut_vec(), exp_vec());
         end
         checks++;
         if ((key_press & key_release) !== '0) begin
            errors++;
            $display("FAIL one_event e=%0d: got %b want 0",
                     e, key_press & key_release);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_toggle();
      test_simultaneous();
      test_reset_mid();
      test_long();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
